// File: rtl/fifo_n2w_pkg.sv
// Shared defaults for the narrow-write / wide-read FIFO.
// A word read out is always two consecutive bytes.
package fifo_n2w_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 3;
    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned BYTES_PER_WORD = 2;

endpackage

// File: rtl/fifo_n2w_if.sv
// Byte-in / pair-out FIFO bus; master is the producer/consumer side, slave is the FIFO.
interface fifo_n2w_if
    import fifo_n2w_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);

    logic                            wr;
    logic                            rd;
    logic [DATA_WIDTH-1:0]           w_data;
    logic [BYTES_PER_WORD*DATA_WIDTH-1:0] r_data;
    logic                            full;
    logic                            empty;
    logic [ADDR_WIDTH:0]             count;

    modport master (
        output wr, rd, w_data,
        input  r_data, full, empty, count
    );

    modport slave (
        input  wr, rd, w_data,
        output r_data, full, empty, count
    );

endinterface

// File: rtl/fifo_ctrl_n2w.sv
// Pointer/count bookkeeping for the byte-in / pair-out FIFO.
// Byte write pointer and pair read pointer both carry a wrap bit.
module fifo_ctrl_n2w #(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned RA_W       = (ADDR_WIDTH > 1) ? ADDR_WIDTH - 1 : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [RA_W-1:0]       r_addr,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count
);

    localparam logic [ADDR_WIDTH:0]   FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   PAIR_CNT = (ADDR_WIDTH+1)'(2);
    localparam logic [ADDR_WIDTH:0]   W_ONE    = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] R_ONE    = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH:0]   w_ptr;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic                  we;
    logic                  re;

    // Occupancy in bytes; full/empty come from this, never from pointer equality.
    always_comb begin
        count = w_ptr - {r_ptr, 1'b0};
        full  = (count == FULL_CNT);
        empty = (count < PAIR_CNT);
        we    = wr & ~full;
        re    = rd & ~empty;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr <= '0;
            r_ptr <= '0;
        end else begin
            if (we) w_ptr <= w_ptr + W_ONE;
            if (re) r_ptr <= r_ptr + R_ONE;
        end
    end

    assign w_addr = w_ptr[ADDR_WIDTH-1:0];

    // With a two-byte store there is only one pair slot.
    if (ADDR_WIDTH > 1) begin : g_raddr
        assign r_addr = r_ptr[ADDR_WIDTH-2:0];
    end else begin : g_raddr_one
        assign r_addr = '0;
    end

endmodule

// File: rtl/fifo_n2w.sv
// Narrow-write / wide-read FIFO: one byte in per write, oldest byte pair out per read.
// r_data is show-ahead, straight from storage at the head pair.
module fifo_n2w
    import fifo_n2w_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic        clk,
    input  logic        reset,
    fifo_n2w_if.slave   bus
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned RA_W  = (ADDR_WIDTH > 1) ? ADDR_WIDTH - 1 : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [RA_W-1:0]       r_addr;
    logic [ADDR_WIDTH-1:0] head_lo;
    logic [ADDR_WIDTH-1:0] head_hi;
    logic                  full;
    logic                  empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  we;

    fifo_ctrl_n2w #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RA_W       (RA_W)
    ) u_ctrl (
        .clk    (clk),
        .reset  (reset),
        .wr     (bus.wr),
        .rd     (bus.rd),
        .w_addr (w_addr),
        .r_addr (r_addr),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    assign we = bus.wr & ~full;

    // Pairs always start on an even byte address.
    if (ADDR_WIDTH > 1) begin : g_head
        assign head_lo = {r_addr, 1'b0};
        assign head_hi = {r_addr, 1'b1};
    end else begin : g_head_one
        assign head_lo = 1'b0;
        assign head_hi = 1'b1;
    end

    // Byte storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) mem[w_addr] <= bus.w_data;
    end

    always_comb begin
        bus.r_data = {mem[head_hi], mem[head_lo]};
        bus.full   = full;
        bus.empty  = empty;
        bus.count  = count;
    end

endmodule

// File: tb/tb_fifo_n2w.sv
// Scoreboard bench for fifo_n2w: byte-queue reference model, directed plan then random traffic.
module tb_fifo_n2w;
    import fifo_n2w_pkg::*;

    localparam int unsigned AW  = 3;
    localparam int unsigned DW  = 8;
    localparam int          CAP = 1 << AW;

    typedef struct {
        int           count;
        bit           full;
        bit           empty;
        logic [15:0]  word;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    fifo_n2w_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    fifo_n2w #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [7:0] mq[$];
    exp_t exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model applies the FIFO rules to a plain byte queue.
    task automatic step(input bit w, input bit r, input bit rs, input logic [7:0] d);
        exp_t e;
        bit acc_w;
        bit acc_r;
        @(negedge clk);
        bus.wr     = w;
        bus.rd     = r;
        bus.w_data = d;
        reset      = rs;
        if (rs) begin
            mq.delete();
        end else begin
            acc_w = w && (mq.size() < CAP);
            acc_r = r && (mq.size() >= 2);
            if (acc_r) begin
                void'(mq.pop_front());
                void'(mq.pop_front());
            end
            if (acc_w) mq.push_back(d);
        end
        e.count = mq.size();
        e.full  = (mq.size() == CAP);
        e.empty = (mq.size() < 2);
        e.word  = (mq.size() >= 2) ? {mq[1], mq[0]} : 16'h0;
        exp_q.push_back(e);
    endtask

    task automatic wr_byte(input logic [7:0] d);
        step(1'b1, 1'b0, 1'b0, d);
    endtask

    task automatic rd_pair();
        step(1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    // Monitor: one expected observation per clock, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("count", int'(bus.count), e.count);
                chk("full",  int'(bus.full),  int'(e.full));
                chk("empty", int'(bus.empty), int'(e.empty));
                if (!e.empty) chk("r_data", int'(bus.r_data), int'(e.word));
            end
        end
    end

    initial begin
        logic [7:0] v;
        int bias_w;
        int bias_r;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        bus.w_data = '0;

        // Reset, then idle with stray reads
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        rd_pair();
        rd_pair();

        // Single byte is not a word; read at count=1 ignored
        wr_byte(8'h11);
        rd_pair();
        wr_byte(8'h22);
        rd_pair();

        // Fill, overflow drop, drain
        for (int i = 1; i <= 8; i++) wr_byte(8'(i));
        wr_byte(8'h99);
        for (int i = 0; i < 4; i++) rd_pair();
        rd_pair();

        // Simultaneous read/write with odd leftover, across pointer wrap
        wr_byte(8'h0A);
        wr_byte(8'h0B);
        v = 8'h0C;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0, v);
            wr_byte(v + 8'h01);
            v = v + 8'h02;
        end
        for (int i = 0; i < 2; i++) rd_pair();

        // Full plus rd/wr in the same cycle: write dropped
        while (mq.size() < CAP) wr_byte(8'($urandom_range(0, 255)));
        step(1'b1, 1'b1, 1'b0, 8'hEE);
        for (int i = 0; i < 4; i++) rd_pair();

        // Reset mid-operation with an odd byte pending
        for (int i = 0; i < 5; i++) wr_byte(8'h40 + 8'(i));
        step(1'b1, 1'b1, 1'b1, 8'h55);
        wr_byte(8'h31);
        wr_byte(8'h32);
        rd_pair();

        // Random traffic with phase-varying bias to hit full and empty often
        for (int ph = 0; ph < 12; ph++) begin
            bias_w = (ph % 3 == 0) ? 85 : ((ph % 3 == 1) ? 50 : 20);
            bias_r = (ph % 3 == 0) ? 20 : ((ph % 3 == 1) ? 50 : 85);
            for (int i = 0; i < 40; i++) begin
                step(($urandom_range(0, 99) < bias_w),
                     ($urandom_range(0, 99) < bias_r),
                     ($urandom_range(0, 199) == 0),
                     8'($urandom_range(0, 255)));
            end
        end
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // Let the monitor drain the scoreboard, bounded
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) chk("scoreboard_drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
